// File: rtl/idma_xif_issuer.sv
// idma_xif_issuer: CV-X-IF initiator that queues pre-encoded iDMA instructions and issues them one at a time.
// Latency: push into an empty FIFO -> issue_valid_o after 2 cycles; rsp_valid_o 1 cycle after reject/result, same cycle as a no-writeback commit.
// Backpressure: cmd_ready_o low while the command FIFO is full; the issue payload is held until issue_ready_i.
//
// Ports:
//   clk_i / rst_ni             : clock, asynchronous active-low reset
//   cmd_*                      : command push side (valid/ready, instruction + two operands)
//   issue_* / commit_*         : CV-X-IF issue request/response and commit strobe toward the coprocessor
//   result_*                   : CV-X-IF result channel (accepted only while waiting for a writeback)
//   rsp_*                      : one-cycle completion pulse per command with status and writeback data
//   busy_o                     : a command is queued or in flight
// Optional feature: define IDMA_XIF_ISSUER_TIMEOUT_EN to give up on a result after TIMEOUT_CYCLES
// cycles and report status TIMEOUT; without it the result wait is unbounded.

module idma_xif_issuer #(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned X_RFR_WIDTH    = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [31:0]            cmd_instr_i,
  input  logic [X_RFR_WIDTH-1:0] cmd_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] cmd_rs2_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs2_o,
  output logic [1:0]             issue_rs_valid_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  output logic                   rsp_valid_o,
  output logic [1:0]             rsp_status_o,
  output logic [X_RFR_WIDTH-1:0] rsp_data_o,
  output logic                   busy_o
);

  localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(CMD_DEPTH + 1);

  localparam logic [1:0] StOk       = 2'd0;
  localparam logic [1:0] StRejected = 2'd1;
  localparam logic [1:0] StMismatch = 2'd2;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("idma_xif_issuer: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES non-zero");
  end

  typedef struct packed {
    logic [31:0]            instr;
    logic [X_RFR_WIDTH-1:0] rs1;
    logic [X_RFR_WIDTH-1:0] rs2;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_RES = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t                  mem_q [CMD_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  cmd_t                  head;
  logic                  push, pop;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic                  wb_q, wb_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [X_RFR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  issue_vld, commit_vld, res_rdy, commit_rsp;

`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] StTimeout = 2'd3;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  assign cmd_ready_o = (count_q != CntW'(CMD_DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  // ISSUE is only reachable with a non-empty FIFO, so a handshake always has a head to pop.
  assign pop         = (state_q == ISSUE) && issue_ready_i;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: cmd_instr_i, rs1: cmd_rs1_i, rs2: cmd_rs2_i};
  end

  // ---------------------------------------------------------------------------
  // Issue / commit / result sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    wb_d         = wb_q;
    rsp_vld_d    = 1'b0;
    rsp_status_d = StOk;
    rsp_data_d   = '0;
    issue_vld    = 1'b0;
    commit_vld   = 1'b0;
    res_rdy      = 1'b0;
    commit_rsp   = 1'b0;
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
    tmo_cnt_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        issue_vld = 1'b1;
        if (issue_ready_i) begin
          if (!issue_accept_i) begin
            rsp_vld_d    = 1'b1;
            rsp_status_d = StRejected;
            id_d         = id_q + X_ID_WIDTH'(1);
            state_d      = IDLE;
          end else begin
            wb_d    = issue_writeback_i;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit_vld = 1'b1;
        if (wb_q) begin
          state_d = WAIT_RES;
        end else begin
          // No writeback: completion is reported alongside the commit strobe.
          commit_rsp = 1'b1;
          id_d       = id_q + X_ID_WIDTH'(1);
          state_d    = IDLE;
        end
      end
      WAIT_RES: begin
        res_rdy = 1'b1;
        // A result landing on the timeout cycle takes priority over the timeout.
        if (result_valid_i) begin
          rsp_vld_d    = 1'b1;
          rsp_status_d = (result_id_i == id_q) ? StOk : StMismatch;
          rsp_data_d   = result_data_i;
          id_d         = id_q + X_ID_WIDTH'(1);
          state_d      = IDLE;
        end
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          rsp_vld_d    = 1'b1;
          rsp_status_d = StTimeout;
          id_d         = id_q + X_ID_WIDTH'(1);
          state_d      = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      id_q         <= '0;
      wb_q         <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_status_q <= StOk;
      rsp_data_q   <= '0;
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      id_q         <= id_d;
      wb_q         <= wb_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: payloads are zeroed when their strobe is low
  // ---------------------------------------------------------------------------
  assign issue_valid_o    = issue_vld;
  assign issue_instr_o    = issue_vld ? head.instr : '0;
  assign issue_rs1_o      = issue_vld ? head.rs1 : '0;
  assign issue_rs2_o      = issue_vld ? head.rs2 : '0;
  assign issue_rs_valid_o = {2{issue_vld}};
  assign issue_id_o       = issue_vld ? id_q : '0;
  assign commit_valid_o   = commit_vld;
  assign commit_id_o      = commit_vld ? id_q : '0;
  assign commit_kill_o    = 1'b0;
  assign result_ready_o   = res_rdy;
  // The registered response and the commit-cycle response never coincide: COMMIT
  // is always entered from ISSUE, which never registers a response it stays on.
  assign rsp_valid_o      = rsp_vld_q || commit_rsp;
  assign rsp_status_o     = rsp_status_q;
  assign rsp_data_o       = rsp_data_q;
  assign busy_o           = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_idma_xif_issuer.sv
module tb_idma_xif_issuer;
  localparam int XID   = 4;
  localparam int XRFR  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic            clk_i, rst_ni;
  logic            cmd_valid_i, cmd_ready_o;
  logic [31:0]     cmd_instr_i;
  logic [XRFR-1:0] cmd_rs1_i, cmd_rs2_i;
  logic            issue_valid_o, issue_ready_i;
  logic [31:0]     issue_instr_o;
  logic [XRFR-1:0] issue_rs1_o, issue_rs2_o;
  logic [1:0]      issue_rs_valid_o;
  logic [XID-1:0]  issue_id_o;
  logic            issue_accept_i, issue_writeback_i;
  logic            commit_valid_o, commit_kill_o;
  logic [XID-1:0]  commit_id_o;
  logic            result_valid_i, result_ready_o;
  logic [XID-1:0]  result_id_i;
  logic [XRFR-1:0] result_data_i;
  logic            rsp_valid_o;
  logic [1:0]      rsp_status_o;
  logic [XRFR-1:0] rsp_data_o;
  logic            busy_o;

  idma_xif_issuer #(
    .X_ID_WIDTH(XID), .X_RFR_WIDTH(XRFR), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_instr_i(cmd_instr_i),
    .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
    .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o), .issue_rs_valid_o(issue_rs_valid_o),
    .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
    .result_data_i(result_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]     instr;
    logic [XRFR-1:0] rs1;
    logic [XRFR-1:0] rs2;
    int              pcyc;
  } mcmd_t;

  // Stimulus knobs (percentages) and directed-command queue.
  int              push_pct, rdy_pct, acc_pct, wb_pct, res_pct, mis_pct;
  bit              force_id_en, force_data_en;
  logic [XID-1:0]  force_id;
  logic [XRFR-1:0] force_data;
  mcmd_t           dq[$];

  // Reference model: commands waiting in order plus a timeline of when the
  // issuer is free and when each expected strobe lands.
  mcmd_t          cq[$];
  int             cyc, idle_from, commit_at, rsp_at, wait_from;
  bit             waiting;
  logic [XID-1:0] mid, commit_idv;
  logic [1:0]     rsp_st;
  logic [XRFR-1:0] rsp_dat;

  // Observations used by the directed literal checks.
  logic [1:0]      seen_st[$];
  logic [XRFR-1:0] seen_dat[$];
  logic [XID-1:0]  seen_cid[$];
  logic [XID-1:0]  seen_iid[$];
  int              first_issue_cyc, first_push_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        cq.delete(); cyc = 0; idle_from = 0; commit_at = -1; rsp_at = -1; wait_from = 0;
        waiting = 0; mid = '0; commit_idv = '0; rsp_st = 0; rsp_dat = '0;
        seen_st.delete(); seen_dat.delete(); seen_cid.delete(); seen_iid.delete();
        first_issue_cyc = -1; first_push_cyc = -1;
      end else begin
        bit e_issue, e_commit, e_rsp, e_rr, e_busy, e_rdy;
        int start;
        e_rdy   = cq.size() < DEPTH;
        e_issue = 0;
        if (!waiting && cq.size() > 0) begin
          start   = ((idle_from > cq[0].pcyc + 1) ? idle_from : cq[0].pcyc + 1) + 1;
          e_issue = (cyc >= start);
        end
        e_commit = (cyc == commit_at);
        e_rsp    = (cyc == rsp_at);
        e_rr     = waiting && (cyc >= wait_from);
        e_busy   = (cq.size() > 0) || waiting || (cyc < idle_from) || e_issue;

        chk("cmd_ready", cmd_ready_o, e_rdy);
        chk("issue_valid", issue_valid_o, e_issue);
        chk("commit_valid", commit_valid_o, e_commit);
        chk("commit_kill", commit_kill_o, 0);
        chk("result_ready", result_ready_o, e_rr);
        chk("rsp_valid", rsp_valid_o, e_rsp);
        chk("busy", busy_o, e_busy);
        if (e_issue) begin
          chk("issue_instr", issue_instr_o, cq[0].instr);
          chk("issue_rs1", issue_rs1_o, cq[0].rs1);
          chk("issue_rs2", issue_rs2_o, cq[0].rs2);
          chk("issue_rs_valid", issue_rs_valid_o, 2'b11);
          chk("issue_id", issue_id_o, mid);
        end
        if (e_commit) chk("commit_id", commit_id_o, commit_idv);
        if (e_rsp) begin
          chk("rsp_status", rsp_status_o, rsp_st);
          chk("rsp_data", rsp_data_o, rsp_dat);
        end

        if (rsp_valid_o) begin seen_st.push_back(rsp_status_o); seen_dat.push_back(rsp_data_o); end
        if (commit_valid_o) seen_cid.push_back(commit_id_o);
        if (issue_valid_o && issue_ready_i) seen_iid.push_back(issue_id_o);
        if (issue_valid_o && first_issue_cyc < 0) first_issue_cyc = cyc;

        if (e_issue && issue_ready_i) begin
          void'(cq.pop_front());
          if (!issue_accept_i) begin
            rsp_at = cyc + 1; rsp_st = 2'd1; rsp_dat = '0; mid++; idle_from = cyc + 1;
          end else begin
            commit_at = cyc + 1; commit_idv = mid;
            if (!issue_writeback_i) begin
              rsp_at = cyc + 1; rsp_st = 2'd0; rsp_dat = '0; mid++; idle_from = cyc + 2;
            end else begin
              waiting = 1; wait_from = cyc + 2; idle_from = 32'h7fff_ffff;
            end
          end
        end
        if (e_rr) begin
          if (result_valid_i) begin
            rsp_at = cyc + 1; rsp_st = (result_id_i == mid) ? 2'd0 : 2'd2; rsp_dat = result_data_i;
            mid++; waiting = 0; idle_from = cyc + 1;
          end
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
          else if (cyc - wait_from == TMO - 1) begin
            rsp_at = cyc + 1; rsp_st = 2'd3; rsp_dat = '0; mid++; waiting = 0; idle_from = cyc + 1;
          end
`endif
        end
        if (cmd_valid_i && e_rdy) begin
          cq.push_back('{instr: cmd_instr_i, rs1: cmd_rs1_i, rs2: cmd_rs2_i, pcyc: cyc});
          if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        cyc++;
      end
    end
  end

  task automatic set_knobs(input int pp, input int rp, input int ap, input int wp, input int sp, input int mp);
    push_pct = pp; rdy_pct = rp; acc_pct = ap; wb_pct = wp; res_pct = sp; mis_pct = mp;
  endtask

  task automatic drive_cycle();
    if (cmd_valid_i && cmd_ready_o && dq.size() > 0) void'(dq.pop_front());
    @(posedge clk_i); #1;
    if (dq.size() > 0) begin
      cmd_valid_i = 1'b1; cmd_instr_i = dq[0].instr; cmd_rs1_i = dq[0].rs1; cmd_rs2_i = dq[0].rs2;
    end else if ($urandom_range(99) < push_pct) begin
      cmd_valid_i = 1'b1; cmd_instr_i = $urandom; cmd_rs1_i = XRFR'($urandom); cmd_rs2_i = XRFR'($urandom);
    end else begin
      cmd_valid_i = 1'b0;
    end
    issue_ready_i     = $urandom_range(99) < rdy_pct;
    issue_accept_i    = $urandom_range(99) < acc_pct;
    issue_writeback_i = $urandom_range(99) < wb_pct;
    result_valid_i    = $urandom_range(99) < res_pct;
    if (force_id_en)                     result_id_i = force_id;
    else if ($urandom_range(99) < mis_pct) result_id_i = XID'($urandom);
    else                                 result_id_i = mid;
    result_data_i = force_data_en ? force_data : XRFR'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic push_dir(input logic [31:0] instr, input logic [XRFR-1:0] rs1, input logic [XRFR-1:0] rs2);
    dq.push_back('{instr: instr, rs1: rs1, rs2: rs2, pcyc: 0});
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    cmd_valid_i = 0; issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
    result_valid_i = 0; result_id_i = '0; result_data_i = '0;
    force_id_en = 0; force_data_en = 0;
    set_knobs(0, 0, 0, 0, 0, 0);
    dq.delete();
    #1;
    chk("rst_issue_valid", issue_valid_o, 0);
    chk("rst_commit_valid", commit_valid_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result_ready", result_ready_o, 0);
    chk("rst_issue_instr", issue_instr_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1;
    cmd_valid_i = 0; cmd_instr_i = '0; cmd_rs1_i = '0; cmd_rs2_i = '0;
    issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
    result_valid_i = 0; result_id_i = '0; result_data_i = '0;
    force_id = '0; force_data = '0;

    // Single writeback command: commit id 0, OK with data 7, two-cycle issue latency.
    do_reset();
    set_knobs(0, 100, 100, 100, 100, 0);
    force_id_en = 1; force_id = 4'd0; force_data_en = 1; force_data = 32'h7;
    push_dir(32'h0000_205B, 32'h1000, 32'h40);
    run(12);
    chk("t1_n_commit", seen_cid.size(), 1);
    if (seen_cid.size() > 0) chk("t1_commit_id", seen_cid[0], 0);
    chk("t1_n_rsp", seen_st.size(), 1);
    if (seen_st.size() > 0) begin
      chk("t1_status", seen_st[0], 0);
      chk("t1_data", seen_dat[0], 32'h7);
    end
    chk("t1_issue_latency", first_issue_cyc - first_push_cyc, 2);
    chk("t1_model_id", mid, 1);

    // Reject then accept: statuses 1 then 0, second command issues with id 1.
    do_reset();
    set_knobs(0, 100, 0, 0, 0, 0);
    push_dir(32'h0000_105B, 32'h11, 32'h22);
    run(6);
    acc_pct = 100;
    push_dir(32'h0000_305B, 32'h33, 32'h44);
    run(8);
    chk("t2_n_rsp", seen_st.size(), 2);
    if (seen_st.size() > 1) begin
      chk("t2_status_rej", seen_st[0], 1);
      chk("t2_status_ok", seen_st[1], 0);
    end
    chk("t2_n_issue", seen_iid.size(), 2);
    if (seen_iid.size() > 1) chk("t2_second_id", seen_iid[1], 1);
    chk("t2_n_commit", seen_cid.size(), 1);

    // Issue stalled: payload stable, FIFO full, no commit.
    do_reset();
    set_knobs(0, 0, 100, 0, 0, 0);
    for (int i = 0; i < 5; i++) push_dir(32'h100 + i, 32'h200 + i, 32'h300 + i);
    run(12);
    chk("t3_cmd_ready", cmd_ready_o, 0);
    chk("t3_issue_valid", issue_valid_o, 1);
    chk("t3_issue_instr", issue_instr_o, 32'h100);
    chk("t3_n_commit", seen_cid.size(), 0);
    chk("t3_pending_push", dq.size(), 1);

    // Reset lands mid-issue; then 17 no-writeback commands exercise id wrap.
    do_reset();
    set_knobs(0, 100, 100, 0, 0, 0);
    for (int i = 0; i < 17; i++) push_dir(32'h5B + (i << 12), i, 17 - i);
    run(80);
    chk("t4_n_rsp", seen_st.size(), 17);
    chk("t4_n_commit", seen_cid.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < seen_cid.size()) chk("t4_commit_id", seen_cid[i], i % 16);
      if (i < seen_st.size()) chk("t4_status", seen_st[i], 0);
    end

    // Result always carries id 3: ids 0,1,2 mismatch, id 3 matches; data forwarded.
    do_reset();
    set_knobs(0, 100, 100, 100, 100, 0);
    force_id_en = 1; force_id = 4'd3; force_data_en = 1; force_data = 32'hABCD;
    for (int i = 0; i < 4; i++) push_dir(32'h205B, i, i);
    run(40);
    chk("t5_n_rsp", seen_st.size(), 4);
    if (seen_st.size() > 3) begin
      chk("t5_status_id2", seen_st[2], 2);
      chk("t5_status_id3", seen_st[3], 0);
      chk("t5_data_id2", seen_dat[2], 32'hABCD);
    end

    // No result ever arrives.
    do_reset();
    set_knobs(0, 100, 100, 100, 0, 0);
    push_dir(32'h205B, 32'h1, 32'h2);
    run(TMO + 20);
`ifdef IDMA_XIF_ISSUER_TIMEOUT_EN
    chk("t6_n_rsp", seen_st.size(), 1);
    if (seen_st.size() > 0) chk("t6_status_timeout", seen_st[0], 3);
    chk("t6_busy", busy_o, 0);
`else
    chk("t6_n_rsp", seen_st.size(), 0);
    chk("t6_busy", busy_o, 1);
    chk("t6_result_ready", result_ready_o, 1);
`endif

    // Randomized traffic, then drain.
    do_reset();
    set_knobs(40, 60, 80, 50, 30, 20);
    run(3000);
    set_knobs(0, 100, 100, 50, 100, 0);
    run(60);
    chk("t7_drained_busy", busy_o, 0);
    chk("t7_rsp_count", seen_st.size(), seen_iid.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
